// File: rtl/pkt_store_fwd_pkg.sv
// Shared types for the store-and-forward packet FIFO: packet descriptor layout.
package pkt_store_fwd_pkg;

  localparam int LEN_W = 16;

  typedef struct packed {
    logic             single;
    logic [LEN_W-1:0] len;
  } pkt_desc_t;

endpackage

// File: rtl/pkt_store_fwd_fifo_chk.sv
// Flags the deadlock where a single oversize packet fills the data FIFO with no complete packet stored.
module pkt_store_fwd_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic data_full,
  input logic pkt_empty
);

  a_no_oversize_pkt: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(data_full && pkt_empty));

endmodule

// File: rtl/sc_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on rdata whenever not empty.
module sc_fwft_fifo #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_wr_s, do_rd_s;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // A full FIFO may still take a write in the same cycle its head leaves.
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);

  // Next-pointer computation
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (do_rd_s) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, deliberately unreset
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pkt_store_fwd_fifo.sv
// Store-and-forward stream FIFO: holds whole packets, releases each one LAT clocks after its
// last beat is written, and rebuilds out_tlast from the recorded beat count.
module pkt_store_fwd_fifo
  import pkt_store_fwd_pkg::*;
#(
  parameter int    DSIZE      = 32,
  parameter int    KSIZE      = 4,
  parameter string USE_KEEP   = "OFF",
  parameter int    DATA_DEPTH = 8192,
  parameter int    PKT_DEPTH  = 4,
  parameter int    LAT        = 6
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [DSIZE-1:0] in_tdata,
  input  logic [KSIZE-1:0] in_tkeep,
  input  logic             in_tvalid,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic [DSIZE-1:0] out_tdata,
  output logic [KSIZE-1:0] out_tkeep,
  output logic             out_tuser,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready,
  output logic             data_full,
  output logic             pkt_empty
);

  localparam bit KEEP_ON = (USE_KEEP == "ON");
  localparam int DW      = KEEP_ON ? DSIZE + KSIZE : DSIZE;
  localparam int PD      = (PKT_DEPTH < 4) ? 4 : PKT_DEPTH;
  localparam int CW      = $clog2(PD + 1);

  logic [DW-1:0]    d_wdata_s, d_rdata_s;
  logic             data_empty_s, pkt_full_s;
  pkt_desc_t        desc_w_s, desc_r_s;
  logic             in_acc_s, in_last_acc_s, out_hs_s, out_last_hs_s, rel_s;
  logic [LEN_W-1:0] w_cnt_q, w_cnt_d, out_cnt_q, out_cnt_d;
  logic [CW-1:0]    credit_q, credit_d;

  assign in_tready     = !data_full && !pkt_full_s;
  assign in_acc_s      = in_tvalid && in_tready;
  assign in_last_acc_s = in_acc_s && in_tlast;
  assign out_tvalid    = !pkt_empty && !data_empty_s && (credit_q != '0);
  assign out_hs_s      = out_tvalid && out_tready;
  assign out_last_hs_s = out_hs_s && out_tlast;
  assign out_tlast     = !pkt_empty && (desc_r_s.single || (out_cnt_q == desc_r_s.len));
  assign out_tuser     = 1'b0;
  assign out_tdata     = d_rdata_s[DSIZE-1:0];
  assign desc_w_s      = '{single: (w_cnt_q == 16'd0), len: w_cnt_q};

  generate
    if (KEEP_ON) begin : g_keep
      assign d_wdata_s = {in_tkeep, in_tdata};
      assign out_tkeep = d_rdata_s[DW-1:DSIZE];
    end else begin : g_nokeep
      logic unused_keep_s;
      assign unused_keep_s = ^in_tkeep;
      assign d_wdata_s     = in_tdata;
      assign out_tkeep     = {KSIZE{1'b1}};
    end
  endgenerate

  sc_fwft_fifo #(.DSIZE(DW), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(aclk), .rst_n(aresetn), .wr_en(in_acc_s), .wdata(d_wdata_s),
    .rd_en(out_hs_s), .rdata(d_rdata_s), .full(data_full), .empty(data_empty_s)
  );

  sc_fwft_fifo #(.DSIZE($bits(pkt_desc_t)), .DEPTH(PD)) u_desc_fifo (
    .clk(aclk), .rst_n(aresetn), .wr_en(in_last_acc_s), .wdata(desc_w_s),
    .rd_en(out_last_hs_s), .rdata(desc_r_s), .full(pkt_full_s), .empty(pkt_empty)
  );

  // The release pulse trails the input last handshake by LAT clocks.
  generate
    if (LAT == 0) begin : g_nodly
      assign rel_s = in_last_acc_s;
    end else begin : g_dly
      logic [LAT-1:0] dly_q, dly_d;
      assign dly_d = (dly_q << 1'b1) | LAT'(in_last_acc_s);
      assign rel_s = dly_q[LAT-1];
      // Release delay shift register
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end
    end
  endgenerate

  // Beat counters and release credit
  always_comb begin
    w_cnt_d   = w_cnt_q;
    out_cnt_d = out_cnt_q;
    credit_d  = credit_q;
    if (in_last_acc_s) begin
      w_cnt_d = 16'd0;
    end else if (in_acc_s) begin
      w_cnt_d = w_cnt_q + 16'd1;
    end else begin
      w_cnt_d = w_cnt_q;
    end
    if (out_last_hs_s) begin
      out_cnt_d = 16'd0;
    end else if (out_hs_s) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end else begin
      out_cnt_d = out_cnt_q;
    end
    case ({rel_s, out_last_hs_s})
      2'b10:   credit_d = credit_q + CW'(1'b1);
      2'b01:   credit_d = credit_q - CW'(1'b1);
      default: credit_d = credit_q;
    endcase
  end

  // Counter registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_cnt_q   <= '0;
      out_cnt_q <= '0;
      credit_q  <= '0;
    end else begin
      w_cnt_q   <= w_cnt_d;
      out_cnt_q <= out_cnt_d;
      credit_q  <= credit_d;
    end
  end

  pkt_store_fwd_fifo_chk u_chk (
    .clk(aclk), .rst_n(aresetn), .data_full(data_full), .pkt_empty(pkt_empty)
  );

endmodule

// File: tb/tb_pkt_store_fwd_fifo.sv
// Self-checking bench for pkt_store_fwd_fifo: scoreboard of {keep,last,data} beats plus timing checks.
module tb_pkt_store_fwd_fifo;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] in_tdata = 32'd0;
  logic [3:0]  in_tkeep = 4'h3;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic [3:0]  out_tkeep;
  logic        out_tuser, out_tvalid, out_tlast;
  logic        out_tready = 1'b0;
  logic        data_full, pkt_empty;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int          obs_t[$];

  pkt_store_fwd_fifo dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser(out_tuser),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .data_full(data_full), .pkt_empty(pkt_empty)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor: records every beat that will be handed over at the next edge
  always @(negedge aclk) begin
    if (aresetn && out_tvalid && out_tready) begin
      obs_q.push_back({out_tkeep, out_tlast, out_tdata});
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Present one beat, wait for acceptance, record expectation; returns 1ns after the accepting edge.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    while (!in_tready && guard < 5000) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (!in_tready) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL in_tready_timeout got 0 want 1 (data %h)", d);
    end else begin
      exp_q.push_back({4'hF, l, d});
    end
    @(posedge aclk); #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 20000) begin
      @(posedge aclk); #1;
      guard++;
    end
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    vec_cnt++; if (out_tvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_tvalid got %b want 0", out_tvalid); end
    vec_cnt++; if (out_tlast !== 1'b0)  begin err_cnt++; $display("FAIL reset_tlast got %b want 0", out_tlast); end
    vec_cnt++; if (in_tready !== 1'b1)  begin err_cnt++; $display("FAIL reset_tready got %b want 1", in_tready); end
    vec_cnt++; if (pkt_empty !== 1'b1)  begin err_cnt++; $display("FAIL reset_pkt_empty got %b want 1", pkt_empty); end
    vec_cnt++; if (data_full !== 1'b0)  begin err_cnt++; $display("FAIL reset_data_full got %b want 0", data_full); end
    vec_cnt++; if (out_tuser !== 1'b0)  begin err_cnt++; $display("FAIL reset_tuser got %b want 0", out_tuser); end
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_single_latency();
    logic [36:0] e, o;
    out_tready = 1'b1;
    drive_beat(32'h0000_00A5, 1'b1);
    in_tvalid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      vec_cnt++;
      if (out_tvalid !== (k == 6)) begin
        err_cnt++;
        $display("FAIL single_latency edge N+%0d got %b want %b", k, out_tvalid, (k == 6));
      end
      if (k < 6) begin
        @(posedge aclk); #1;
      end
    end
    vec_cnt++;
    if ({out_tkeep, out_tlast, out_tdata} !== {4'hF, 1'b1, 32'h0000_00A5}) begin
      err_cnt++;
      $display("FAIL single_head got %h want %h", {out_tkeep, out_tlast, out_tdata}, {4'hF, 1'b1, 32'h0000_00A5});
    end
    @(posedge aclk); #1;
    vec_cnt++;
    if (out_tvalid !== 1'b0 || pkt_empty !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_after_pop got valid=%b empty=%b want 0 1", out_tvalid, pkt_empty);
    end
    wait_drain();
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL single_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL single_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_back_to_back();
    logic [36:0] e, o;
    bit contiguous;
    out_tready = 1'b1;
    drive_beat(32'd1, 1'b0);
    drive_beat(32'd2, 1'b0);
    drive_beat(32'd3, 1'b0);
    drive_beat(32'd4, 1'b1);
    drive_beat(32'd5, 1'b0);
    drive_beat(32'd6, 1'b1);
    in_tvalid = 1'b0;
    wait_drain();
    contiguous = (obs_t.size() == 6);
    for (int i = 1; i < obs_t.size(); i++) begin
      if (obs_t[i] != obs_t[i-1] + 1) contiguous = 1'b0;
    end
    vec_cnt++;
    if (!contiguous) begin err_cnt++; $display("FAIL b2b_contiguous got gaps (%0d beats) want 6 consecutive", obs_t.size()); end
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL b2b_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL b2b_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_partial_stall();
    logic [36:0] e, o;
    bit early;
    out_tready = 1'b1;
    drive_beat(32'h10, 1'b0);
    drive_beat(32'h11, 1'b0);
    drive_beat(32'h12, 1'b0);
    in_tvalid = 1'b0;
    early = 1'b0;
    repeat (20) begin
      if (out_tvalid !== 1'b0) early = 1'b1;
      @(posedge aclk); #1;
    end
    vec_cnt++;
    if (early) begin err_cnt++; $display("FAIL stall_hold got valid=1 want 0"); end
    drive_beat(32'h13, 1'b1);
    in_tvalid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      vec_cnt++;
      if (out_tvalid !== (k == 6)) begin
        err_cnt++;
        $display("FAIL stall_release edge N+%0d got %b want %b", k, out_tvalid, (k == 6));
      end
      if (k < 6) begin
        @(posedge aclk); #1;
      end
    end
    wait_drain();
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL stall_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL stall_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_pkt_full();
    logic [36:0] e, o;
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(32'h20 + i, 1'b1);
    in_tvalid = 1'b0;
    vec_cnt++;
    if (in_tready !== 1'b0) begin err_cnt++; $display("FAIL pktfull_ready got %b want 0", in_tready); end
    repeat (10) @(posedge aclk);
    #1;
    vec_cnt++;
    if (in_tready !== 1'b0 || out_tvalid !== 1'b1) begin
      err_cnt++;
      $display("FAIL pktfull_hold got ready=%b valid=%b want 0 1", in_tready, out_tvalid);
    end
    out_tready = 1'b1;
    @(posedge aclk); #1;
    out_tready = 1'b0;
    vec_cnt++;
    if (in_tready !== 1'b1) begin err_cnt++; $display("FAIL pktfull_reopen got %b want 1", in_tready); end
    drive_beat(32'h24, 1'b1);
    in_tvalid = 1'b0;
    out_tready = 1'b1;
    wait_drain();
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL pktfull_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL pktfull_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_backpressure();
    logic [36:0] e, o;
    bit drv_done;
    drv_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          int len;
          len = $urandom_range(1, 64);
          for (int b = 0; b < len; b++) drive_beat($urandom, (b == len - 1));
          if ($urandom_range(0, 3) == 0) begin
            in_tvalid = 1'b0;
            @(posedge aclk); #1;
          end
        end
        in_tvalid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_tready = ($urandom_range(0, 1) == 1);
          @(posedge aclk); #1;
        end
      end
    join
    out_tready = 1'b1;
    wait_drain();
    vec_cnt++;
    if (obs_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL bp_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL bp_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_reset_mid();
    logic [36:0] e, o;
    out_tready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drive_beat(32'h100 + p, 1'b0);
      drive_beat(32'h110 + p, 1'b0);
      drive_beat(32'h120 + p, 1'b1);
    end
    drive_beat(32'h1FE, 1'b0);
    drive_beat(32'h1FF, 1'b0);
    repeat (8) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    vec_cnt++;
    if (out_tvalid !== 1'b0 || in_tready !== 1'b1 || pkt_empty !== 1'b1) begin
      err_cnt++;
      $display("FAIL midreset got valid=%b ready=%b empty=%b want 0 1 1", out_tvalid, in_tready, pkt_empty);
    end
    in_tvalid = 1'b0;
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    out_tready = 1'b1;
    drive_beat(32'h30, 1'b0);
    drive_beat(32'h31, 1'b0);
    drive_beat(32'h32, 1'b1);
    in_tvalid = 1'b0;
    wait_drain();
    vec_cnt++;
    if (obs_q.size() != 3) begin err_cnt++; $display("FAIL midreset_beats got %0d want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vec_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL midreset_beat got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_partial_stall();
    test_pkt_full();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
